// File: rtl/n_bit_seq_divider.sv
// Unsigned restoring divider: one quotient bit per clock behind a start/done
// handshake, with divide-by-zero flagged rather than computed.
module n_bit_seq_divider #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state;
  logic [N-1:0]  dvd;
  logic [N-1:0]  dsr;
  logic [N:0]    rem;
  logic [CW-1:0] cnt;
  logic          zero;

  logic [N:0]    shifted;
  logic [N:0]    rem_next;
  logic          qbit;

  // One restoring step: the dividend register doubles as the quotient
  // shift register, so quotient bits enter at the LSB as dividend bits leave.
  always_comb begin
    shifted  = (rem << 1) | {{N{1'b0}}, dvd[N-1]};
    qbit     = (shifted >= {1'b0, dsr});
    rem_next = qbit ? (shifted - {1'b0, dsr}) : shifted;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      dvd         <= '0;
      dsr         <= '0;
      rem         <= '0;
      cnt         <= '0;
      zero        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvd         <= dividend;
            dsr         <= divisor;
            rem         <= '0;
            cnt         <= '0;
            zero        <= (divisor == '0);
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            state       <= (divisor == '0) ? DONE : CALC;
          end
        end
        CALC: begin
          rem <= rem_next;
          dvd <= {dvd[N-2:0], qbit};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) state <= DONE;
        end
        DONE: begin
          // For a zero divisor dvd was never shifted, so it still holds the dividend.
          quotient    <= zero ? '1 : dvd;
          remainder   <= zero ? dvd : rem[N-1:0];
          div_by_zero <= zero;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_n_bit_seq_divider.sv
// Scoreboard bench for n_bit_seq_divider: the driver pushes expected results
// with their due cycle; a negedge monitor pops and compares on every done.
module tb_n_bit_seq_divider;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  n_bit_seq_divider #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
    int           due;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int next_free = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Called at a negedge; presents operands with start high, records the
  // expected result and returns at the negedge after the accepting edge.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] q, input logic [N-1:0] r, input logic dbz);
    int   acc;
    exp_t e;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    acc      = (cyc + 1 > next_free) ? cyc + 1 : next_free;
    e.q      = q;
    e.r      = r;
    e.dbz    = dbz;
    e.due    = acc + ((b == '0) ? 1 : N + 1);
    sb.push_back(e);
    next_free = acc + ((b == '0) ? 2 : N + 2);
    while (cyc < acc) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_pending", sb.size(), 0);
    sb.delete();
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", div_by_zero, e.dbz);
        chk("done_cycle", cyc, e.due);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  logic [N-1:0] vec_a [4] = '{8'd255, 8'd5, 8'd0, 8'd255};
  logic [N-1:0] vec_b [4] = '{8'd1, 8'd10, 8'd3, 8'd255};
  logic [N-1:0] vec_q [4] = '{8'd255, 8'd0, 8'd0, 8'd1};
  logic [N-1:0] vec_r [4] = '{8'd0, 8'd5, 8'd0, 8'd0};

  initial begin
    logic [N-1:0] a;
    logic [N-1:0] b;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single-cycle start, latency and busy
    issue(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("no_early_done", done, 0);
    drain();

    for (int i = 0; i < 4; i++) begin
      issue(vec_a[i], vec_b[i], vec_q[i], vec_r[i], 1'b0);
      start = 1'b0;
      drain();
    end

    // divide by zero, then a normal op clears the flag
    issue(8'd200, 8'd0, 8'd255, 8'd200, 1'b1);
    start = 1'b0;
    drain();
    issue(8'd9, 8'd3, 8'd3, 8'd0, 1'b0);
    start = 1'b0;
    drain();

    // start during CALC must be ignored
    issue(8'd50, 8'd5, 8'd10, 8'd0, 1'b0);
    start = 1'b0;
    repeat (3) @(negedge clk);
    dividend = 8'd99;
    divisor  = 8'd4;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // reset in the middle of CALC aborts the operation
    issue(8'd77, 8'd6, 8'd12, 8'd5, 1'b0);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    next_free = 0;
    @(negedge clk);
    issue(8'd12, 8'd13, 8'd0, 8'd12, 1'b0);
    start = 1'b0;
    drain();

    // back-to-back stream with start held high
    for (int i = 0; i < 1000; i++) begin
      a = N'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom_range(1, 255));
      if (b == '0) issue(a, b, '1, a, 1'b1);
      else         issue(a, b, a / b, a % b, 1'b0);
    end
    start = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
